adder_4bit_seq_ctrl: RTL and testbench

Sequencer that performs a (4*NIBBLES)-bit addition by time-multiplexing one external 4-bit ripple adder slice.
- Latches wide operands on a start request.
- Presents one nibble per cycle to the slice (LSB nibble first).
- Carries the slice carry-out between cycles.
- Assembles the wide sum and signals completion.
- Sits between a requesting datapath and a single shared 4-bit adder instance.

---
 rtl/adder_4bit_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_adder_4bit_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_4bit_seq_ctrl.sv
// adder_4bit_seq_ctrl
// Performs a (4*NIBBLES)-bit addition by time-multiplexing a single external
// 4-bit adder slice. Operands are latched on an accepted start, one nibble per
// cycle is presented to the slice (LSB first), the slice carry is registered
// between cycles, and the assembled sum is held until the next accepted start.
module adder_4bit_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [3:0]      nib_a, nib_b;
  logic            last_nib;
  logic            accept;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  // A start is honoured only when no operation is in flight (IDLE or DONE).
  assign accept = start && (state_q != S_RUN);

  // Next-state and output decode; the slice is only driven while running.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    busy    = 1'b0;
    done    = 1'b0;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Acceptance handled below, shared with DONE.
      end

      S_RUN: begin
        busy    = 1'b1;
        add_a   = nib_a;
        add_b   = nib_b;
        add_cin = carry_q;
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[4*i +: 4] = add_s;
          end
        end
        carry_d = add_cout;
        if (last_nib) begin
          // Index is left at its last value so it never wraps inside RUN.
          cout_d  = add_cout;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A start in IDLE, or in DONE for back-to-back operation, latches operands.
    if (accept) begin
      a_d     = op_a;
      b_d     = op_b;
      carry_d = cin;
      idx_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      state_d = S_RUN;
    end
  end

  // State and datapath registers; an asserted rst aborts any operation at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the operand latches are a handful of flops rather than a memory
      // array, so resetting them with everything else is cheap and keeps the
      // slice inputs deterministic after an abort.
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_adder_4bit_seq_ctrl.sv
// Testbench for adder_4bit_seq_ctrl: a 4-nibble and a 1-nibble instance, each
// wired to a behavioural 4-bit adder slice. Expected results are pushed into a
// per-instance queue when a start is issued; monitors pop and compare on done.
module tb_adder_4bit_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- 4-nibble instance ----------------
  logic        rst4, start4, cin4;
  logic [15:0] op_a4, op_b4;
  logic        busy4, done4, cout4;
  logic [15:0] sum4;
  logic [3:0]  add_a4, add_b4, add_s4;
  logic        add_cin4, add_cout4;

  assign {add_cout4, add_s4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_cin4};

  adder_4bit_seq_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .op_a(op_a4), .op_b(op_b4),
    .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_s(add_s4), .add_cout(add_cout4)
  );

  // ---------------- 1-nibble instance ----------------
  logic        rst1, start1, cin1;
  logic [3:0]  op_a1, op_b1;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;
  logic [3:0]  add_a1, add_b1, add_s1;
  logic        add_cin1, add_cout1;

  assign {add_cout1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_cin1};

  adder_4bit_seq_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .op_a(op_a1), .op_b(op_b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_s(add_s1), .add_cout(add_cout1)
  );

  // Scoreboards: {cout, sum}
  logic [16:0] q4[$];
  logic [4:0]  q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 4-nibble instance.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut4 done: unexpected done pulse, sum=0x%0h (t=%0t)", sum4, $time);
      end else begin
        logic [16:0] e;
        e = q4.pop_front();
        check("dut4 sum", 32'(sum4), 32'(e[15:0]));
        check("dut4 cout", 32'(cout4), 32'(e[16]));
      end
    end
  end

  // Monitor for the 1-nibble instance.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 done: unexpected done pulse, sum=0x%0h (t=%0t)", sum1, $time);
      end else begin
        logic [4:0] e;
        e = q1.pop_front();
        check("dut1 sum", 32'(sum1), 32'(e[3:0]));
        check("dut1 cout", 32'(cout1), 32'(e[4]));
      end
    end
  end

  // Issue a start to dut4 from a negedge; operands are scrambled after the edge.
  task automatic issue4(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic ec, input bit push);
    start4 = 1'b1;
    op_a4  = a;
    op_b4  = b;
    cin4   = c;
    if (push) q4.push_back({ec, es});
    @(posedge clk);
    #1;
    start4 = 1'b0;
    op_a4  = ~a;
    op_b4  = ~b;
    cin4   = ~c;
  endtask

  // Walk the four RUN cycles and the DONE cycle of dut4.
  task automatic wait_done4(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, " busy"}, 32'(busy4), 32'd1);
    end
    @(negedge clk);
    check({tag, " done"}, 32'(done4), 32'd1);
    check({tag, " busy in done"}, 32'(busy4), 32'd0);
  endtask

  logic [3:0] t1_a[4];
  logic [3:0] t1_b[4];
  logic       t1_c[4];
  logic       t2_c[4];

  initial begin
    t1_a = '{4'h4, 4'h3, 4'h2, 4'h1};
    t1_b = '{4'hD, 4'hC, 4'hF, 4'h0};
    t1_c = '{1'b0, 1'b1, 1'b1, 1'b1};
    t2_c = '{1'b0, 1'b1, 1'b1, 1'b1};

    rst4 = 1'b1; start4 = 1'b0; op_a4 = '0; op_b4 = '0; cin4 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; op_a1 = '0; op_b1 = '0; cin1 = 1'b0;

    // Reset state
    #12;
    check("reset busy", 32'(busy4), 32'd0);
    check("reset done", 32'(done4), 32'd0);
    check("reset sum", 32'(sum4), 32'd0);
    check("reset cout", 32'(cout4), 32'd0);
    check("reset add_a/add_b/add_cin", 32'({add_a4, add_b4, add_cin4}), 32'd0);
    @(negedge clk);
    rst4 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    // 0x1234 + 0x0FCD + 0 = 0x2201, slice sequence checked nibble by nibble
    issue4(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t1 busy[%0d]", i), 32'(busy4), 32'd1);
      check($sformatf("t1 add_a[%0d]", i), 32'(add_a4), 32'(t1_a[i]));
      check($sformatf("t1 add_b[%0d]", i), 32'(add_b4), 32'(t1_b[i]));
      check($sformatf("t1 add_cin[%0d]", i), 32'(add_cin4), 32'(t1_c[i]));
    end
    @(negedge clk);
    check("t1 done", 32'(done4), 32'd1);
    check("t1 add_a idle", 32'(add_a4), 32'd0);
    @(negedge clk);
    check("t1 done one cycle", 32'(done4), 32'd0);

    // 0xFFFF + 0x0001 + 0: full carry ripple
    issue4(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t2 add_cin[%0d]", i), 32'(add_cin4), 32'(t2_c[i]));
    end
    @(negedge clk);
    check("t2 done", 32'(done4), 32'd1);
    @(negedge clk);

    // 0x8000 + 0x8000 + 1, then back-to-back start in the DONE cycle
    issue4(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
    wait_done4("t3a");
    issue4(16'h0003, 16'h0007, 1'b1, 16'h000B, 1'b0, 1'b1);
    wait_done4("t3b");
    @(negedge clk);

    // start pulses during RUN are ignored
    issue4(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b1);
    @(negedge clk);
    start4 = 1'b1; op_a4 = 16'hAAAA; op_b4 = 16'h5555; cin4 = 1'b1;
    @(negedge clk);
    check("t4 busy r2", 32'(busy4), 32'd1);
    @(negedge clk);
    check("t4 busy r3", 32'(busy4), 32'd1);
    start4 = 1'b0;
    @(negedge clk);
    check("t4 busy r4", 32'(busy4), 32'd1);
    @(negedge clk);
    check("t4 done", 32'(done4), 32'd1);
    @(negedge clk);
    check("t4 idle after done", 32'({busy4, done4}), 32'd0);

    // Asynchronous reset in the 2nd RUN cycle aborts with no done
    issue4(16'h1234, 16'h0FCD, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst4 = 1'b1;
    #1;
    check("t5 busy after rst", 32'(busy4), 32'd0);
    check("t5 sum after rst", 32'(sum4), 32'd0);
    check("t5 cout after rst", 32'(cout4), 32'd0);
    check("t5 add_* after rst", 32'({add_a4, add_b4, add_cin4}), 32'd0);
    @(negedge clk);
    rst4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t5 no done[%0d]", i), 32'({busy4, done4}), 32'd0);
    end
    issue4(16'h000C, 16'h000D, 1'b0, 16'h0019, 1'b0, 1'b1);
    wait_done4("t5b");
    @(negedge clk);

    // NIBBLES=1: 0x5 + 0xE + 1 = 0x14
    start1 = 1'b1; op_a1 = 4'h5; op_b1 = 4'hE; cin1 = 1'b1;
    q1.push_back({1'b1, 4'h4});
    @(posedge clk);
    #1;
    start1 = 1'b0; op_a1 = 4'h0; op_b1 = 4'h0; cin1 = 1'b0;
    @(negedge clk);
    check("n1 busy", 32'(busy1), 32'd1);
    check("n1 add_a", 32'(add_a1), 32'h5);
    check("n1 add_cin", 32'(add_cin1), 32'd1);
    @(negedge clk);
    check("n1 done", 32'(done1), 32'd1);
    check("n1 busy in done", 32'(busy1), 32'd0);
    @(negedge clk);
    check("n1 idle", 32'({busy1, done1}), 32'd0);

    // Every expected result must have been consumed by a done pulse
    check("dut4 pending results", 32'(q4.size()), 32'd0);
    check("dut1 pending results", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
